// File: rtl/pdu_io_host.sv
// IO-bus initiator standing in for the CPU on the PDU peripheral port.
// Runs the hex-entry loop: valid handshake, switch read, LED echo, digit accumulate, 7-seg commit.
module pdu_io_host #(
    parameter logic [7:0] ADDR_OUT0  = 8'h00,
    parameter logic [7:0] ADDR_READY = 8'h04,
    parameter logic [7:0] ADDR_OUT1  = 8'h08,
    parameter logic [7:0] ADDR_IN    = 8'h0c,
    parameter logic [7:0] ADDR_VALID = 8'h10,
    parameter int         MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din,
    output logic        busy,
    output logic [31:0] acc,
    output logic [3:0]  digits,
    output logic [7:0]  commits
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        WR_RDY1 = 3'd2,
        POLL    = 3'd3,
        RD_IN   = 3'd4,
        WR_RDY0 = 3'd5,
        WR_OUT0 = 3'd6,
        WR_OUT1 = 3'd7
    } state_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

    state_t      state_reg, state_next;
    logic        last_valid_reg;
    logic [4:0]  in_reg;
    logic [31:0] acc_reg;
    logic [3:0]  digits_reg;
    logic [7:0]  commits_reg;

    logic valid_edge;
    assign valid_edge = io_din[0] != last_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = SYNC;
            SYNC:    state_next = WR_RDY1;
            WR_RDY1: state_next = POLL;
            // Dropping en wins over an edge arriving in the same cycle.
            POLL: begin
                if (!en)            state_next = IDLE;
                else if (valid_edge) state_next = RD_IN;
            end
            RD_IN:   state_next = WR_RDY0;
            WR_RDY0: state_next = WR_OUT0;
            WR_OUT0: state_next = in_reg[4] ? WR_OUT1 : WR_RDY1;
            WR_OUT1: state_next = WR_RDY1;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        io_addr = 8'h00;
        io_dout = 32'h0;
        io_we   = 1'b0;
        case (state_reg)
            SYNC, POLL: io_addr = ADDR_VALID;
            RD_IN:      io_addr = ADDR_IN;
            WR_RDY1: begin
                io_addr = ADDR_READY;
                io_dout = 32'h1;
                io_we   = 1'b1;
            end
            WR_RDY0: begin
                io_addr = ADDR_READY;
                io_we   = 1'b1;
            end
            WR_OUT0: begin
                io_addr = ADDR_OUT0;
                io_dout = {27'b0, in_reg};
                io_we   = 1'b1;
            end
            WR_OUT1: begin
                io_addr = ADDR_OUT1;
                io_dout = acc_reg;
                io_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_valid_reg <= 1'b0;
            in_reg         <= 5'h0;
            acc_reg        <= 32'h0;
            digits_reg     <= 4'h0;
            commits_reg    <= 8'h0;
        end else begin
            case (state_reg)
                // Resample valid on entry so a stale level is never taken as an edge.
                SYNC: last_valid_reg <= io_din[0];
                POLL: if (en && valid_edge) last_valid_reg <= io_din[0];
                RD_IN: in_reg <= io_din[4:0];
                WR_OUT0: begin
                    if (!in_reg[4]) begin
                        acc_reg <= {acc_reg[27:0], in_reg[3:0]};
                        if (digits_reg < MAX_D) digits_reg <= digits_reg + 4'd1;
                    end
                end
                WR_OUT1: begin
                    acc_reg     <= 32'h0;
                    digits_reg  <= 4'h0;
                    commits_reg <= commits_reg + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = state_reg != IDLE;
    assign acc     = acc_reg;
    assign digits  = digits_reg;
    assign commits = commits_reg;

endmodule

// File: tb/tb_pdu_io_host.sv
// Self-checking bench for pdu_io_host: behavioural IO responder, write logger, entry table.
module tb_pdu_io_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic [31:0] io_din;
    logic        busy;
    logic [31:0] acc;
    logic [3:0]  digits;
    logic [7:0]  commits;

    logic       valid;
    logic [4:0] sw;

    pdu_io_host dut (
        .clk(clk), .rst(rst), .en(en),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_din(io_din),
        .busy(busy), .acc(acc), .digits(digits), .commits(commits)
    );

    always #5 clk = ~clk;

    assign io_din = (io_addr == 8'h10) ? {31'b0, valid} :
                    (io_addr == 8'h0c) ? {27'b0, sw} : 32'h0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];
    int  rd_in_cnt;

    always @(posedge clk) begin
        if (io_we) wq.push_back('{a: io_addr, d: io_dout});
        if (io_addr == 8'h0c) rd_in_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input int k, input logic [7:0] a, input logic [31:0] d);
        if (wq.size() > k) begin
            check({name, "_addr"}, 32'(wq[k].a), 32'(a));
            check({name, "_data"}, wq[k].d, d);
        end else begin
            check({name, "_missing"}, 32'(wq.size()), 32'(k + 1));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  sw;
        logic [31:0] acc;
        logic [3:0]  digits;
        logic [7:0]  commits;
        logic [31:0] out1;
    } vec_t;
    vec_t tbl[20];

    initial begin
        tbl[0]  = '{5'h0A, 32'h0000000A, 4'd1, 8'd0, 32'h0};
        tbl[1]  = '{5'h03, 32'h000000A3, 4'd2, 8'd0, 32'h0};
        tbl[2]  = '{5'h10, 32'h00000000, 4'd0, 8'd1, 32'h000000A3};
        tbl[3]  = '{5'h01, 32'h00000001, 4'd1, 8'd1, 32'h0};
        tbl[4]  = '{5'h02, 32'h00000012, 4'd2, 8'd1, 32'h0};
        tbl[5]  = '{5'h03, 32'h00000123, 4'd3, 8'd1, 32'h0};
        tbl[6]  = '{5'h04, 32'h00001234, 4'd4, 8'd1, 32'h0};
        tbl[7]  = '{5'h1F, 32'h00000000, 4'd0, 8'd2, 32'h00001234};
        tbl[8]  = '{5'h01, 32'h00000001, 4'd1, 8'd2, 32'h0};
        tbl[9]  = '{5'h02, 32'h00000012, 4'd2, 8'd2, 32'h0};
        tbl[10] = '{5'h03, 32'h00000123, 4'd3, 8'd2, 32'h0};
        tbl[11] = '{5'h04, 32'h00001234, 4'd4, 8'd2, 32'h0};
        tbl[12] = '{5'h05, 32'h00012345, 4'd5, 8'd2, 32'h0};
        tbl[13] = '{5'h06, 32'h00123456, 4'd6, 8'd2, 32'h0};
        tbl[14] = '{5'h07, 32'h01234567, 4'd7, 8'd2, 32'h0};
        tbl[15] = '{5'h08, 32'h12345678, 4'd8, 8'd2, 32'h0};
        tbl[16] = '{5'h09, 32'h23456789, 4'd8, 8'd2, 32'h0};
        tbl[17] = '{5'h10, 32'h00000000, 4'd0, 8'd3, 32'h23456789};
        tbl[18] = '{5'h0E, 32'h0000000E, 4'd1, 8'd3, 32'h0};
        tbl[19] = '{5'h0B, 32'h000000EB, 4'd2, 8'd3, 32'h0};

        // Reset with valid already high
        rst = 1'b1; en = 1'b0; valid = 1'b1; sw = 5'h0; rd_in_cnt = 0;
        cycles(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(io_we), 32'd0);
        check("rst_addr", 32'(io_addr), 32'h0);
        check("rst_acc", acc, 32'h0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_commits", 32'(commits), 32'd0);

        wq.delete();
        rst = 1'b0; en = 1'b1;
        cycles(105);
        $display("startup: %0d writes", wq.size());
        check("start_nwr", 32'(wq.size()), 32'd1);
        check_wr("start_wr0", 0, 8'h04, 32'h1);
        check("start_poll_addr", 32'(io_addr), 32'h10);
        check("start_poll_busy", 32'(busy), 32'd1);
        check("start_no_rd", 32'(rd_in_cnt), 32'd0);

        // Entry table: one valid toggle per record
        for (int i = 0; i < 20; i++) begin
            wq.delete();
            sw = tbl[i].sw;
            valid = ~valid;
            cycles(8);
            $display("entry %0d sw=%h acc=%h digits=%0d commits=%0d writes=%0d",
                     i, sw, acc, digits, commits, wq.size());
            check_wr("ent_rdy0", 0, 8'h04, 32'h0);
            check_wr("ent_out0", 1, 8'h00, {27'b0, tbl[i].sw});
            if (tbl[i].sw[4]) begin
                check("ent_nwr_commit", 32'(wq.size()), 32'd4);
                check_wr("ent_out1", 2, 8'h08, tbl[i].out1);
                check_wr("ent_rdy1", 3, 8'h04, 32'h1);
            end else begin
                check("ent_nwr_digit", 32'(wq.size()), 32'd3);
                check_wr("ent_rdy1", 2, 8'h04, 32'h1);
            end
            check("ent_acc", acc, tbl[i].acc);
            check("ent_digits", 32'(digits), 32'(tbl[i].digits));
            check("ent_commits", 32'(commits), 32'(tbl[i].commits));
        end

        // Abort from POLL, second pass with a simultaneous valid edge, then resume
        for (int pass = 0; pass < 2; pass++) begin
            wq.delete();
            rd_in_cnt = 0;
            en = 1'b0;
            if (pass == 1) valid = ~valid;
            cycles(1);
            $display("abort pass %0d: busy=%0d addr=%h", pass, busy, io_addr);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_addr", 32'(io_addr), 32'h0);
            cycles(3);
            check("abort_nwr", 32'(wq.size()), 32'd0);
            en = 1'b1;
            cycles(1);
            check("resume_sync_addr", 32'(io_addr), 32'h10);
            check("resume_sync_we", 32'(io_we), 32'd0);
            cycles(1);
            check("resume_rdy1_we", 32'(io_we), 32'd1);
            check("resume_rdy1_addr", 32'(io_addr), 32'h04);
            check("resume_rdy1_dout", io_dout, 32'h1);
            cycles(6);
            check("resume_nwr", 32'(wq.size()), 32'd1);
            check("resume_no_rd", 32'(rd_in_cnt), 32'd0);
            check("resume_acc", acc, 32'h000000EB);
        end

        // Async reset landing in WR_OUT0
        sw = 5'h05;
        valid = ~valid;
        cycles(3);
        check("mid_out0_we", 32'(io_we), 32'd1);
        check("mid_out0_addr", 32'(io_addr), 32'h00);
        #2 rst = 1'b1;
        #1;
        $display("async reset: we=%0d busy=%0d acc=%h digits=%0d commits=%0d",
                 io_we, busy, acc, digits, commits);
        check("arst_we", 32'(io_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_acc", acc, 32'h0);
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_commits", 32'(commits), 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
